rock_driver: RTL

//  Consumer side of the amplitude/frequency controller: reads amplitude level A,

---
 rtl/rock_driver_pkg.sv | 27 ++
 rtl/rock_driver_tick_prescaler.sv | 35 +++
 rtl/rock_driver.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rock_driver_pkg.sv
// rock_driver_pkg
//   Shared definitions for the rocking-motor driver: FSM state encoding,
//   PWM counter width, default timing constants and the half-period length
//   helper.
package rock_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SWING_R = 2'd1,
    ST_SWING_L = 2'd2,
    ST_BRAKE   = 2'd3
  } state_e;

  localparam int PWM_W           = 3;
  localparam int DEF_PRESCALE    = 1000;
  localparam int DEF_BASE_HALF   = 64;
  localparam int DEF_STEP        = 8;
  localparam int DEF_BRAKE_TICKS = 16;

  // Half-period length in ticks for frequency level f. Evaluated in 8 bits;
  // parameters must keep base_half - 7*step >= 1.
  function automatic logic [7:0] half_len(input int base_half, input int step,
                                          input logic [2:0] f);
    half_len = 8'(base_half - step * int'(f));
  endfunction

endpackage

// File: rtl/rock_driver_tick_prescaler.sv
// rock_driver_tick_prescaler
//   Free-running divider producing the motion tick.
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset
//     tick     out  high for one clk when the count is PRESCALE-1
module rock_driver_tick_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/rock_driver.sv
// rock_driver
//   Turns amplitude level A, frequency level F and the stop flag F0 into the
//   rocking-motor drive. Each half swing ends in a direction reversal where
//   new A/F values are taken over; a stop request brakes for BRAKE_TICKS
//   ticks before returning to rest.
//   Ports:
//     clk        in   system clock
//     reset_n    in   asynchronous active-low reset
//     A[2:0]     in   amplitude level (0 = no drive)
//     F[2:0]     in   frequency level
//     F0         in   stop request
//     motor_en   out  H-bridge enable
//     motor_dir  out  1 = swing right, 0 = swing left
//     pwm        out  drive PWM, duty = A_lat/8
//     half_done  out  one-clk pulse per half-period boundary
//     at_rest    out  high while idle
module rock_driver
  import rock_driver_pkg::*;
#(
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int BASE_HALF   = DEF_BASE_HALF,
  parameter int STEP        = DEF_STEP,
  parameter int BRAKE_TICKS = DEF_BRAKE_TICKS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] A,
  input  logic [2:0] F,
  input  logic       F0,
  output logic       motor_en,
  output logic       motor_dir,
  output logic       pwm,
  output logic       half_done,
  output logic       at_rest
);

  localparam int BW = $clog2(BRAKE_TICKS + 1);
  localparam logic [BW-1:0] BRAKE_LAST = BW'(BRAKE_TICKS - 1);

  logic tick;

  rock_driver_tick_prescaler #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  state_e           state_q,     state_d;
  logic [7:0]       half_cnt_q,  half_cnt_d;
  logic [BW-1:0]    brake_cnt_q, brake_cnt_d;
  logic [2:0]       a_lat_q,     a_lat_d;
  logic [2:0]       f_lat_q,     f_lat_d;
  logic [PWM_W-1:0] pwm_cnt_q,   pwm_cnt_d;
  logic             motor_en_q,  motor_en_d;
  logic             motor_dir_q, motor_dir_d;
  logic             pwm_q,       pwm_d;
  logic             half_done_q, half_done_d;
  logic             at_rest_q,   at_rest_d;
  logic [7:0]       half_last;

  assign half_last = half_len(BASE_HALF, STEP, f_lat_q) - 8'd1;

  always_comb begin
    state_d     = state_q;
    half_cnt_d  = half_cnt_q;
    brake_cnt_d = brake_cnt_q;
    a_lat_d     = a_lat_q;
    f_lat_d     = f_lat_q;
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    half_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!F0 && (A != 3'd0)) begin
          state_d    = ST_SWING_R;
          a_lat_d    = A;
          f_lat_d    = F;
          half_cnt_d = 8'd0;
        end
      end
      ST_SWING_R, ST_SWING_L: begin
        if (tick) begin
          if (half_cnt_q == half_last) begin
            // Reversal point: take over whatever is on the inputs right now.
            half_done_d = 1'b1;
            half_cnt_d  = 8'd0;
            a_lat_d     = A;
            f_lat_d     = F;
            if (F0 || (A == 3'd0)) begin
              state_d     = ST_BRAKE;
              brake_cnt_d = '0;
            end else begin
              state_d = (state_q == ST_SWING_R) ? ST_SWING_L : ST_SWING_R;
            end
          end else begin
            half_cnt_d = half_cnt_q + 8'd1;
          end
        end
      end
      ST_BRAKE: begin
        if (tick) begin
          if (brake_cnt_q == BRAKE_LAST) begin
            state_d     = ST_IDLE;
            brake_cnt_d = '0;
          end else begin
            brake_cnt_d = brake_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the current state and appear one clk later.
    motor_en_d = (state_q != ST_IDLE);
    at_rest_d  = (state_q == ST_IDLE);
    pwm_d      = ((state_q == ST_SWING_R) || (state_q == ST_SWING_L)) &&
                 (pwm_cnt_q < a_lat_q);
    case (state_q)
      ST_SWING_R: motor_dir_d = 1'b1;
      ST_SWING_L: motor_dir_d = 1'b0;
      ST_BRAKE:   motor_dir_d = motor_dir_q;  // brake against last swing direction
      default:    motor_dir_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      half_cnt_q  <= 8'd0;
      brake_cnt_q <= '0;
      a_lat_q     <= 3'd0;
      f_lat_q     <= 3'd0;
      pwm_cnt_q   <= '0;
      motor_en_q  <= 1'b0;
      motor_dir_q <= 1'b0;
      pwm_q       <= 1'b0;
      half_done_q <= 1'b0;
      at_rest_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      half_cnt_q  <= half_cnt_d;
      brake_cnt_q <= brake_cnt_d;
      a_lat_q     <= a_lat_d;
      f_lat_q     <= f_lat_d;
      pwm_cnt_q   <= pwm_cnt_d;
      motor_en_q  <= motor_en_d;
      motor_dir_q <= motor_dir_d;
      pwm_q       <= pwm_d;
      half_done_q <= half_done_d;
      at_rest_q   <= at_rest_d;
    end
  end

  assign motor_en  = motor_en_q;
  assign motor_dir = motor_dir_q;
  assign pwm       = pwm_q;
  assign half_done = half_done_q;
  assign at_rest   = at_rest_q;

endmodule
